riscv_dmi_axil_bridge: RTL and testbench

AXI4-Lite slave that lets a system-bus master (boot core, debug firmware) reach the Debug Module register space over the DMI request/response channel, in parallel with the JTAG DTM path. Each AXI transaction becomes exactly one DMI transaction, with automatic re-issue on DMI busy. The DMI response status is mapped to AXI RESP. It sits upstream of riscv_dm's req_*/resp_* ports, in the DM clock domain.

---
 rtl/riscv_dm_pkg.sv | 24 ++
 rtl/riscv_dmi_axil_bridge.sv | 153 +++++++++++++++
 tb/tb_riscv_dmi_axil_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_dm_pkg.sv
// Shared Debug Module definitions: DMI field widths, DMI op/status codes
// and the AXI response codes used by the system-bus bridge.
package riscv_dm_pkg;

    localparam int DMI_ADDR_WIDTH = 7;
    localparam int DMI_DATA_WIDTH = 32;
    localparam int DMI_OP_WIDTH   = 2;

    typedef enum logic [DMI_OP_WIDTH-1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2
    } dmi_op_e;

    typedef enum logic [DMI_OP_WIDTH-1:0] {
        DMI_RESP_OK     = 2'd0,
        DMI_RESP_FAILED = 2'd2,
        DMI_RESP_BUSY   = 2'd3
    } dmi_resp_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/riscv_dmi_axil_bridge.sv
// AXI4-Lite slave that turns each AXI access into one DMI transaction,
// re-issuing on DMI busy up to MAX_RETRY times before reporting SLVERR.
module riscv_dmi_axil_bridge
    import riscv_dm_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MAX_RETRY      = 4
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr_i,
    input  logic                        s_awvalid_i,
    output logic                        s_awready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb_i,
    input  logic                        s_wvalid_i,
    output logic                        s_wready_o,
    output logic [1:0]                  s_bresp_o,
    output logic                        s_bvalid_o,
    input  logic                        s_bready_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr_i,
    input  logic                        s_arvalid_i,
    output logic                        s_arready_o,
    output logic [AXI_DATA_WIDTH-1:0]   s_rdata_o,
    output logic [1:0]                  s_rresp_o,
    output logic                        s_rvalid_o,
    input  logic                        s_rready_i,
    output logic                        req_valid_o,
    input  logic                        req_ready_i,
    output logic [DMI_ADDR_WIDTH-1:0]   req_addr_o,
    output logic [DMI_DATA_WIDTH-1:0]   req_data_o,
    output logic [DMI_OP_WIDTH-1:0]     req_op_o,
    input  logic                        resp_valid_i,
    output logic                        resp_ready_o,
    input  logic [DMI_DATA_WIDTH-1:0]   resp_data_i,
    input  logic [DMI_OP_WIDTH-1:0]     resp_op_i
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_BRESP, S_RRESP} state_e;

    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] MAX_RETRY_C = RETRY_W'(MAX_RETRY);

    state_e                      state_q, state_d;
    logic [RETRY_W-1:0]          retry_q, retry_d;
    logic [DMI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DMI_DATA_WIDTH-1:0]   data_q, data_d;
    logic [DMI_OP_WIDTH-1:0]     op_q, op_d;
    logic [1:0]                  resp_q, resp_d;
    logic [DMI_DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                        wr_acc, rd_acc, lane;
    logic [AXI_DATA_WIDTH-1:0]   wdata_sh;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_sh;
    logic                        unused_bits;

    // Writes win a tie with reads; a read is only taken with no complete write offered.
    assign wr_acc = (state_q == S_IDLE) && s_awvalid_i && s_wvalid_i;
    assign rd_acc = (state_q == S_IDLE) && s_arvalid_i && !(s_awvalid_i && s_wvalid_i);

    assign lane     = (AXI_DATA_WIDTH == 64) ? s_awaddr_i[2] : 1'b0;
    assign wdata_sh = s_wdata_i >> (lane ? 32 : 0);
    assign wstrb_sh = s_wstrb_i >> (lane ? 4 : 0);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        addr_d  = addr_q;
        data_d  = data_q;
        op_d    = op_q;
        resp_d  = resp_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (wr_acc) begin
                    retry_d = '0;
                    addr_d  = s_awaddr_i[2 +: DMI_ADDR_WIDTH];
                    data_d  = wdata_sh[31:0];
                    op_d    = DMI_OP_WRITE;
                    if (wstrb_sh[3:0] != 4'hF) begin
                        resp_d  = AXI_RESP_SLVERR;
                        state_d = S_BRESP;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (rd_acc) begin
                    retry_d = '0;
                    addr_d  = s_araddr_i[2 +: DMI_ADDR_WIDTH];
                    data_d  = '0;
                    op_d    = DMI_OP_READ;
                    state_d = S_REQ;
                end
            end
            S_REQ: if (req_ready_i) state_d = S_WAIT;
            S_WAIT: begin
                if (resp_valid_i) begin
                    state_d = (op_q == DMI_OP_WRITE) ? S_BRESP : S_RRESP;
                    resp_d  = AXI_RESP_SLVERR;
                    rdata_d = '0;
                    if (resp_op_i == DMI_RESP_OK) begin
                        resp_d  = AXI_RESP_OKAY;
                        rdata_d = resp_data_i;
                    end else if (resp_op_i == DMI_RESP_BUSY && retry_q < MAX_RETRY_C) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_BRESP: if (s_bready_i) state_d = S_IDLE;
            S_RRESP: if (s_rready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            retry_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= '0;
            resp_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    assign s_awready_o  = wr_acc;
    assign s_wready_o   = wr_acc;
    assign s_arready_o  = rd_acc;
    assign req_valid_o  = (state_q == S_REQ);
    assign req_addr_o   = addr_q;
    assign req_data_o   = data_q;
    assign req_op_o     = op_q;
    assign resp_ready_o = (state_q == S_WAIT);
    assign s_bvalid_o   = (state_q == S_BRESP);
    assign s_bresp_o    = s_bvalid_o ? resp_q : 2'b00;
    assign s_rvalid_o   = (state_q == S_RRESP);
    assign s_rresp_o    = s_rvalid_o ? resp_q : 2'b00;
    // Read data is mirrored into every 32-bit lane so either word address sees it.
    assign s_rdata_o    = s_rvalid_o ? {(AXI_DATA_WIDTH/32){rdata_q}} : '0;

    assign unused_bits = ^{s_awaddr_i, s_araddr_i, wdata_sh, wstrb_sh};

endmodule

// File: tb/tb_riscv_dmi_axil_bridge.sv
// Self-checking bench: directed and randomized AXI-Lite accesses against a
// scripted DMI responder, compared with an outcome model of the bridge.
module tb_riscv_dmi_axil_bridge;
    localparam int MAX_RETRY = 4;

    logic        clk_i = 0, rstn_i = 0;
    logic [11:0] s_awaddr_i = 0, s_araddr_i = 0;
    logic        s_awvalid_i = 0, s_wvalid_i = 0, s_arvalid_i = 0, s_bready_i = 0, s_rready_i = 0;
    logic [31:0] s_wdata_i = 0;
    logic [3:0]  s_wstrb_i = 0;
    logic        s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rvalid_o;
    logic [1:0]  s_bresp_o, s_rresp_o;
    logic [31:0] s_rdata_o;
    logic        req_valid_o, req_ready_i = 0, resp_valid_i = 0, resp_ready_o;
    logic [6:0]  req_addr_o;
    logic [31:0] req_data_o, resp_data_i = 0;
    logic [1:0]  req_op_o, resp_op_i = 0;

    riscv_dmi_axil_bridge #(.AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32), .MAX_RETRY(MAX_RETRY)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
        .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
        .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
        .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .req_data_o(req_data_o), .req_op_o(req_op_o),
        .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
        .resp_data_i(resp_data_i), .resp_op_i(resp_op_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0, n_err = 0;

    // Observations gathered while servicing one transaction.
    int          obs_nreq;
    bit          obs_same, obs_b, obs_r, obs_timeout, obs_ar_leak;
    logic [6:0]  obs_addr;
    logic [31:0] obs_data, obs_rdata;
    logic [1:0]  obs_op, obs_resp;

    task automatic accept(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output bit ok);
        ok = 0;
        @(negedge clk_i);
        if (wr) begin
            s_awaddr_i = a; s_wdata_i = wd; s_wstrb_i = st; s_awvalid_i = 1; s_wvalid_i = 1;
        end else begin
            s_araddr_i = a; s_arvalid_i = 1;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (wr ? (s_awready_o && s_wready_o) : s_arready_o) begin ok = 1; break; end
            @(negedge clk_i);
        end
        @(negedge clk_i);
        s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0;
    endtask

    // Plays the DMI target: answers busy nbusy times, then fin_op.
    task automatic serve(input int nbusy, input logic [1:0] fin_op, input logic [31:0] rd,
                         input int rr_delay, input bit stop_at_wait);
        int dly = 0, rw = 0, rdl = 0, bsent = 0;
        bit done = 0, have = 0;
        obs_nreq = 0; obs_same = 1; obs_b = 0; obs_r = 0; obs_timeout = 0; obs_ar_leak = 0;
        obs_resp = 0; obs_rdata = 0; obs_addr = 0; obs_data = 0; obs_op = 0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk_i);
            if (s_arready_o) obs_ar_leak = 1;
            req_ready_i = 0; resp_valid_i = 0; resp_op_i = 0; s_bready_i = 0; s_rready_i = 0;
            if (req_valid_o) begin
                if (!have) begin
                    obs_addr = req_addr_o; obs_data = req_data_o; obs_op = req_op_o; have = 1;
                end else if (req_addr_o !== obs_addr || req_data_o !== obs_data || req_op_o !== obs_op)
                    obs_same = 0;
                if (dly >= rr_delay) begin req_ready_i = 1; obs_nreq++; dly = 0; end
                else dly++;
            end
            if (resp_ready_o) begin
                if (stop_at_wait) return;
                if (rw < rdl) rw++;
                else begin
                    resp_valid_i = 1; resp_data_i = rd;
                    resp_op_i = (bsent < nbusy) ? 2'd3 : fin_op;
                    bsent++; rw = 0; rdl = $urandom_range(0, 2);
                end
            end
            if (s_bvalid_o) begin obs_b = 1; obs_resp = s_bresp_o; s_bready_i = 1; done = 1; end
            if (s_rvalid_o) begin
                obs_r = 1; obs_resp = s_rresp_o; obs_rdata = s_rdata_o; s_rready_i = 1; done = 1;
            end
        end
        if (!done) obs_timeout = 1;
        @(negedge clk_i);
        req_ready_i = 0; resp_valid_i = 0; s_bready_i = 0; s_rready_i = 0;
    endtask

    // Outcome model: how many DMI requests and which AXI response to expect.
    function automatic int exp_nreq(input logic [3:0] st, input bit wr, input int nbusy);
        if (wr && st != 4'hF) return 0;
        return (nbusy > MAX_RETRY) ? MAX_RETRY + 1 : nbusy + 1;
    endfunction
    function automatic logic [1:0] exp_resp(input logic [3:0] st, input bit wr,
                                            input int nbusy, input logic [1:0] fin_op);
        if (wr && st != 4'hF) return 2'b10;
        if (nbusy > MAX_RETRY) return 2'b10;
        return (fin_op == 2'd0) ? 2'b00 : 2'b10;
    endfunction

    task automatic test_reset();
        n_cmp++;
        if ({s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o, req_valid_o, resp_ready_o,
             s_bresp_o, s_rresp_o, s_rdata_o, req_addr_o, req_data_o, req_op_o} !== '0) begin
            n_err++; $display("FAIL reset_outputs: some output nonzero during reset, want all 0");
        end
        repeat (3) @(negedge clk_i);
        rstn_i = 1;
    endtask

    task automatic test_write();
        bit ok;
        accept(1, 12'h040, 32'hDEADBEEF, 4'hF, ok);
        #1;
        n_cmp++;
        if (!(ok && req_valid_o)) begin
            n_err++; $display("FAIL wr_latency: accepted=%0d req_valid=%0d want 1/1", ok, req_valid_o);
        end
        serve(0, 2'd0, 32'h0, 0, 0);
        n_cmp++;
        if ({obs_addr, obs_op, obs_data} !== {7'h10, 2'd2, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL wr_req: addr=%h op=%0d data=%h want 10/2/deadbeef", obs_addr, obs_op, obs_data);
        end
        n_cmp++;
        if (!obs_b || obs_resp !== 2'b00 || obs_nreq != 1) begin
            n_err++; $display("FAIL wr_bresp: b=%0d resp=%0d nreq=%0d want 1/0/1", obs_b, obs_resp, obs_nreq);
        end
    endtask

    task automatic test_read();
        bit ok;
        accept(0, 12'h044, 32'h0, 4'h0, ok);
        serve(0, 2'd0, 32'h00030000, 0, 0);
        n_cmp++;
        if ({obs_addr, obs_op} !== {7'h11, 2'd1}) begin
            n_err++; $display("FAIL rd_req: addr=%h op=%0d want 11/1", obs_addr, obs_op);
        end
        n_cmp++;
        if (!obs_r || obs_resp !== 2'b00 || obs_rdata !== 32'h00030000) begin
            n_err++; $display("FAIL rd_resp: r=%0d resp=%0d data=%h want 1/0/00030000", obs_r, obs_resp, obs_rdata);
        end
    endtask

    task automatic test_busy();
        bit ok;
        accept(0, 12'h100, 32'h0, 4'h0, ok);
        serve(2, 2'd0, 32'h12345678, 0, 0);
        n_cmp++;
        if (obs_nreq != 3 || !obs_same || obs_resp !== 2'b00 || obs_rdata !== 32'h12345678) begin
            n_err++; $display("FAIL busy2: nreq=%0d same=%0d resp=%0d data=%h want 3/1/0/12345678",
                              obs_nreq, obs_same, obs_resp, obs_rdata);
        end
        accept(1, 12'h008, 32'hCAFEF00D, 4'hF, ok);
        serve(MAX_RETRY + 1, 2'd0, 32'h0, 0, 0);
        n_cmp++;
        if (obs_nreq != MAX_RETRY + 1 || !obs_b || obs_resp !== 2'b10) begin
            n_err++; $display("FAIL busy_max: nreq=%0d b=%0d resp=%0d want %0d/1/2",
                              obs_nreq, obs_b, obs_resp, MAX_RETRY + 1);
        end
    endtask

    task automatic test_partial_strobe();
        bit ok;
        accept(1, 12'h040, 32'h11223344, 4'h3, ok);
        #1;
        n_cmp++;
        if (req_valid_o || !s_bvalid_o) begin
            n_err++; $display("FAIL strb_path: req_valid=%0d bvalid=%0d want 0/1", req_valid_o, s_bvalid_o);
        end
        serve(0, 2'd0, 32'h0, 0, 0);
        n_cmp++;
        if (obs_nreq != 0 || obs_resp !== 2'b10) begin
            n_err++; $display("FAIL strb_resp: nreq=%0d resp=%0d want 0/2", obs_nreq, obs_resp);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk_i);
        s_awaddr_i = 12'h0C0; s_wdata_i = 32'hA5A5A5A5; s_wstrb_i = 4'hF; s_awvalid_i = 1; s_wvalid_i = 1;
        s_araddr_i = 12'h0C4; s_arvalid_i = 1;
        #1;
        n_cmp++;
        if (!(s_awready_o && s_wready_o) || s_arready_o) begin
            n_err++; $display("FAIL simul_accept: aw=%0d w=%0d ar=%0d want 1/1/0", s_awready_o, s_wready_o, s_arready_o);
        end
        @(negedge clk_i);
        s_awvalid_i = 0; s_wvalid_i = 0;
        serve(0, 2'd0, 32'h0, 0, 0);
        n_cmp++;
        if (!obs_b || obs_ar_leak || obs_op !== 2'd2 || obs_addr !== 7'h30) begin
            n_err++; $display("FAIL simul_write: b=%0d ar_leak=%0d op=%0d addr=%h want 1/0/2/30",
                              obs_b, obs_ar_leak, obs_op, obs_addr);
        end
        n_cmp++;
        if (!s_arready_o) begin
            n_err++; $display("FAIL simul_read_accept: arready=%0d want 1 in first idle cycle", s_arready_o);
        end
        @(negedge clk_i);
        s_arvalid_i = 0;
        serve(0, 2'd0, 32'h0BADCAFE, 0, 0);
        n_cmp++;
        if (!obs_r || obs_addr !== 7'h31 || obs_rdata !== 32'h0BADCAFE) begin
            n_err++; $display("FAIL simul_read: r=%0d addr=%h data=%h want 1/31/0badcafe", obs_r, obs_addr, obs_rdata);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        accept(1, 12'h1FC, 32'h87654321, 4'hF, ok);
        serve(1, 2'd0, 32'h0, 10, 0);
        n_cmp++;
        if (!obs_same || obs_nreq != 2 || obs_addr !== 7'h7F || obs_data !== 32'h87654321 || obs_resp !== 2'b00) begin
            n_err++; $display("FAIL backpressure: same=%0d nreq=%0d addr=%h data=%h resp=%0d want 1/2/7f/87654321/0",
                              obs_same, obs_nreq, obs_addr, obs_data, obs_resp);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        accept(0, 12'h010, 32'h0, 4'h0, ok);
        serve(0, 2'd0, 32'h0, 0, 1);
        rstn_i = 0;
        #1;
        n_cmp++;
        if ({s_awready_o, s_wready_o, s_arready_o, s_bvalid_o, s_rvalid_o, req_valid_o, resp_ready_o,
             s_bresp_o, s_rresp_o, s_rdata_o, req_addr_o, req_data_o, req_op_o} !== '0) begin
            n_err++; $display("FAIL reset_mid_outputs: some output nonzero after reset in WAIT");
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (s_bvalid_o || s_rvalid_o) seen = 1;
        end
        rstn_i = 1;
        repeat (2) begin
            @(negedge clk_i);
            if (s_bvalid_o || s_rvalid_o) seen = 1;
        end
        n_cmp++;
        if (seen) begin n_err++; $display("FAIL reset_mid_noresp: response valid seen=1 want 0"); end
        accept(0, 12'h014, 32'h0, 4'h0, ok);
        serve(0, 2'd0, 32'h5A5A0001, 0, 0);
        n_cmp++;
        if (!obs_r || obs_resp !== 2'b00 || obs_rdata !== 32'h5A5A0001 || obs_addr !== 7'h05) begin
            n_err++; $display("FAIL reset_fresh_read: r=%0d resp=%0d data=%h addr=%h want 1/0/5a5a0001/05",
                              obs_r, obs_resp, obs_rdata, obs_addr);
        end
    endtask

    task automatic test_random();
        bit ok, wr;
        logic [11:0] a;
        logic [31:0] wd, rd;
        logic [3:0]  st;
        logic [1:0]  fop, er;
        int nb;
        for (int it = 0; it < 12; it++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = 12'($urandom);
            wd  = $urandom;
            rd  = $urandom;
            st  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            nb  = $urandom_range(0, 6);
            fop = 2'($urandom_range(0, 2));
            accept(wr, a, wd, st, ok);
            serve(nb, fop, rd, $urandom_range(0, 3), 0);
            er = exp_resp(st, wr, nb, fop);
            n_cmp++;
            if (obs_timeout || obs_nreq != exp_nreq(st, wr, nb) || obs_resp !== er || obs_b != wr || obs_r != !wr) begin
                n_err++; $display("FAIL rand%0d_outcome: nreq=%0d resp=%0d b=%0d r=%0d to=%0d want nreq=%0d resp=%0d wr=%0d",
                                  it, obs_nreq, obs_resp, obs_b, obs_r, obs_timeout, exp_nreq(st, wr, nb), er, wr);
            end
            if (obs_nreq > 0) begin
                n_cmp++;
                if (!obs_same || obs_addr !== a[8:2] || obs_op !== (wr ? 2'd2 : 2'd1) || (wr && obs_data !== wd)) begin
                    n_err++; $display("FAIL rand%0d_req: addr=%h op=%0d data=%h same=%0d want addr=%h wr=%0d data=%h",
                                      it, obs_addr, obs_op, obs_data, obs_same, a[8:2], wr, wd);
                end
            end
            if (!wr) begin
                n_cmp++;
                if (obs_rdata !== ((er == 2'b00) ? rd : 32'h0)) begin
                    n_err++; $display("FAIL rand%0d_rdata: got %h want %h", it, obs_rdata, (er == 2'b00) ? rd : 32'h0);
                end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_write();
        test_read();
        test_busy();
        test_partial_strobe();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
